// File: rtl/writeback_scoreboard.sv
// Writeback arbiter with scoreboard.
// Single-cycle ALU results and long-latency results share one register-file
// write port. Long results wait in a 2-entry FIFO. A starvation counter makes
// sure a waiting long result still gets written while the ALU stream is busy.
// The busy vector tracks issued long ops and drives the decode stall.
module writeback_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lng_valid,
  input  logic [4:0]  lng_rd,
  input  logic [31:0] lng_data,
  output logic        lng_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        stall,
  output logic        write_en,
  output logic [4:0]  a3,
  output logic [31:0] din,
  output logic [31:0] busy
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  localparam logic [2:0] STARV_MAX = 3'd4;

  wb_ent_t     fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  cnt;
  logic [2:0]  starv;
  logic        wb_lng;       // the write on a3/din came from the FIFO

  logic        fifo_ne, push, pop, alu_win;
  logic        sel_valid;
  wb_ent_t     sel;
  logic [31:0] set_vec, clr_vec;

  assign fifo_ne   = (cnt != 2'd0);
  assign lng_ready = (cnt < 2'd2);
  // Hold the ALU off for one cycle once the FIFO head has waited long enough
  assign alu_ready = !((starv == STARV_MAX) && fifo_ne);
  assign alu_win   = alu_valid && alu_ready;
  // Only entries present at the start of the cycle can pop
  assign pop       = !alu_win && fifo_ne;
  assign push      = lng_valid && lng_ready;

  // Source select: ALU first, otherwise FIFO head
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    if (alu_win) begin
      sel_valid = 1'b1;
      sel.rd    = alu_rd;
      sel.data  = alu_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel       = fifo_mem[rd_ptr];
    end
  end

  // Long-result FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{rd: lng_rd, data: lng_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      cnt <= cnt + 2'd1;
      else if (!push && pop) cnt <= cnt - 2'd1;
    end
  end

  // Starvation counter: counts ALU wins over a waiting FIFO head
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starv <= 3'd0;
    end else if (!fifo_ne || pop) begin
      starv <= 3'd0;
    end else if (alu_win && starv != STARV_MAX) begin
      starv <= starv + 3'd1;
    end
  end

  // Registered write port; x0 results are consumed but never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en <= 1'b0;
      wb_lng   <= 1'b0;
      a3       <= '0;
      din      <= '0;
    end else begin
      write_en <= sel_valid && (sel.rd != 5'd0);
      wb_lng   <= pop && (sel.rd != 5'd0);
      if (sel_valid) begin
        a3  <= sel.rd;
        din <= sel.data;
      end
    end
  end

  assign set_vec = (iss_valid && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;
  assign clr_vec = (write_en && wb_lng) ? (32'd1 << a3) : 32'd0;

  // Scoreboard: set on issue, clear when a long result is captured; set wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= ((busy & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
  end

  assign stall = ((rs1 != 5'd0) && busy[rs1]) ||
                 ((rs2 != 5'd0) && busy[rs2]) ||
                 (iss_valid && (iss_rd != 5'd0) && busy[iss_rd]);

endmodule

// File: doc/writeback_scoreboard.md
WRITEBACK_SCOREBOARD -- requirements
Module: writeback_scoreboard

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst (asynchronous, active-low).
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 alu_valid  in  1  single-cycle ALU result present.
REQ-005 alu_rd  in  5  ALU destination register.
REQ-006 alu_data  in  32  ALU result.
REQ-007 alu_ready  out  1  ALU result accepted this cycle; upstream holds alu_* stable while low.
REQ-008 lng_valid  in  1  long-latency (load/mul/div) result present.
REQ-009 lng_rd  in  5  long-latency destination register.
REQ-010 lng_data  in  32  long-latency result.
REQ-011 lng_ready  out  1  long-result FIFO not full.
REQ-012 iss_valid  in  1  long-latency op issued this cycle.
REQ-013 iss_rd  in  5  destination register of issued op.
REQ-014 rs1, rs2  in  5 each  source registers of the decoding instruction.
REQ-015 stall  out  1  decode must hold.
REQ-016 write_en  out  1  register-file write enable (registered).
REQ-017 a3  out  5  register-file write address (registered).
REQ-018 din  out  32  register-file write data (registered).
REQ-019 busy  out  32  scoreboard vector; bit 0 always 0.

Function
REQ-020 Long-result buffer SHALL be a 2-entry FIFO; push when lng_valid && lng_ready; lng_ready = (count < 2).
REQ-021 Each cycle the arbiter SHALL select at most one source: ALU when alu_valid && alu_ready, otherwise FIFO head if FIFO non-empty.
REQ-022 alu_ready SHALL be 1 except when the starvation counter equals 4 and the FIFO is non-empty.
REQ-023 Starvation counter (3 bits) SHALL increment each cycle the FIFO is non-empty and the ALU wins, reset to 0 when the FIFO pops or is empty, and saturate at 4.
REQ-024 Selected result SHALL appear on write_en/a3/din on the clock edge after selection (latency 1); with no selection write_en=0 and a3/din hold their previous values.
REQ-025 A selected result with rd=0 SHALL be consumed (ALU accepted / FIFO popped) but produce write_en=0.
REQ-026 iss_valid with iss_rd!=0 SHALL set busy[iss_rd] on the next edge.
REQ-027 busy[rd] SHALL clear on the edge that ends the cycle in which write_en=1 for a FIFO-sourced entry with that rd (the regfile capture edge); ALU-sourced writes SHALL NOT clear busy.
REQ-028 Simultaneous set and clear of the same bit SHALL resolve to set.
REQ-029 stall SHALL be combinational: (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]) || (iss_valid && iss_rd!=0 && busy[iss_rd]).
REQ-030 Simultaneous FIFO push and pop with count=2 SHALL NOT occur because lng_ready=0; with count=1 or 0 push and pop in the same cycle SHALL leave count unchanged. When count=0, a pushed entry SHALL NOT be popped in the same cycle.
REQ-031 FIFO read/write pointers SHALL wrap modulo 2.

Reset
REQ-032 While rst=0: write_en=0, a3=0, din=0, busy=0, FIFO empty, pointers 0, starvation counter 0; therefore lng_ready=1, alu_ready=1, stall=0.
REQ-033 Reset assertion mid-operation SHALL discard FIFO contents and busy state immediately, without waiting for a clock edge.
REQ-034 On rst release, the block SHALL accept inputs on the first rising edge.

Verification
REQ-035 ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle write_en=1, a3=5, din=0xDEADBEEF; busy unchanged.
REQ-036 Scoreboard: iss_valid=1, iss_rd=7; later rs1=7 -> stall=1; lng result rd=7, data=0x1234 written -> busy[7] clears one edge after write_en=1, a3=7; then stall=0.
REQ-037 x0: alu_rd=0 and iss_rd=0 -> write_en stays 0, busy[0]=0, stall=0.
REQ-038 Starvation: alu_valid=1 continuously, push one lng result -> after 4 ALU wins alu_ready=0 for one cycle, FIFO entry written, alu_ready returns to 1.
REQ-039 Full FIFO: push 2 lng results while ALU is busy -> lng_ready=0; third lng_valid is held by the source until a pop; no entry is lost, and entries are written in order.
REQ-040 Reset mid-operation: FIFO count=2, busy[3]=1, then pull rst low -> immediately busy=0, lng_ready=1, write_en=0.
